// File: rtl/microseq_ctrl_pkg.sv
// Shared sequencer definitions: sequencing-field encodings, fixed micro-addresses
// and controller states.
package cpu_pkg;

    localparam int UPC_W  = 8;
    localparam int OPC_W  = 5;
    localparam int SLOT_W = 3;
    localparam int CNT_W  = 16;

    localparam logic [UPC_W-1:0] FETCH_ADDR = '0;
    localparam logic [UPC_W-1:0] SKIP_ADDR  = 8'h80;

    typedef enum logic [2:0] {
        SEQ_NEXT  = 3'b000,
        SEQ_DISP  = 3'b001,
        SEQ_FETCH = 3'b010,
        SEQ_HOLD  = 3'b011,
        SEQ_JZ    = 3'b100,
        SEQ_JN    = 3'b101,
        SEQ_JC    = 3'b110,
        SEQ_RSVD  = 3'b111
    } seq_op_e;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } state_e;

endpackage

// File: rtl/microseq_ctrl_if.sv
// Bundle between the microcode datapath and the sequencer: ROM sequencing field,
// IR/flags/handshakes in, micro-PC and status out.
interface microseq_ctrl_if #(
    parameter int UPC_W = 8,
    parameter int OPC_W = 5,
    parameter int CNT_W = 16
);
    logic [2:0]       seq_op;
    logic [OPC_W-1:0] ir_opcode;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             mem_ready;
    logic             halt_req;
    logic [UPC_W-1:0] upc;
    logic             dispatch;
    logic             halted;
    logic             ucode_err;
    logic [CNT_W-1:0] retired;

    modport master (
        output seq_op, ir_opcode, flag_z, flag_n, flag_c, mem_ready, halt_req,
        input  upc, dispatch, halted, ucode_err, retired
    );

    modport slave (
        input  seq_op, ir_opcode, flag_z, flag_n, flag_c, mem_ready, halt_req,
        output upc, dispatch, halted, ucode_err, retired
    );
endinterface

// File: rtl/microseq_ctrl_next_addr.sv
// Combinational next-micro-address mux for the RUN state, plus decoded
// side effects (dispatch, end-of-instruction, microcode error, hold).
import cpu_pkg::*;

module microseq_ctrl_next_addr #(
    parameter int               UPC_W     = cpu_pkg::UPC_W,
    parameter int               OPC_W     = cpu_pkg::OPC_W,
    parameter int               SLOT_W    = cpu_pkg::SLOT_W,
    parameter logic [UPC_W-1:0] SKIP_ADDR = cpu_pkg::SKIP_ADDR
) (
    input  logic [UPC_W-1:0] i_upc,
    input  logic [2:0]       i_seq_op,
    input  logic [OPC_W-1:0] i_ir_opcode,
    input  logic             i_flag_z,
    input  logic             i_flag_n,
    input  logic             i_flag_c,
    output logic [UPC_W-1:0] o_next_upc,
    output logic             o_dispatch,
    output logic             o_fetch,
    output logic             o_err,
    output logic             o_hold
);
    seq_op_e          w_op;
    logic [UPC_W-1:0] w_upc_inc;
    logic [UPC_W-1:0] w_disp_addr;
    logic             w_slot_end;

    assign w_op        = seq_op_e'(i_seq_op);
    assign w_upc_inc   = i_upc + UPC_W'(1);
    assign w_disp_addr = UPC_W'({i_ir_opcode, {SLOT_W{1'b0}}});
    assign w_slot_end  = &i_upc[SLOT_W-1:0];

    always_comb begin
        o_next_upc = w_upc_inc;
        o_dispatch = 1'b0;
        o_fetch    = 1'b0;
        o_err      = 1'b0;
        o_hold     = 1'b0;
        case (w_op)
            // Falling off the end of a slot would run into the next opcode's microcode.
            SEQ_NEXT: begin
                if (w_slot_end) begin
                    o_next_upc = UPC_W'(FETCH_ADDR);
                    o_err      = 1'b1;
                end
            end
            SEQ_DISP: begin
                o_next_upc = w_disp_addr;
                o_dispatch = 1'b1;
            end
            SEQ_FETCH: begin
                o_next_upc = UPC_W'(FETCH_ADDR);
                o_fetch    = 1'b1;
            end
            SEQ_HOLD: begin
                o_next_upc = i_upc;
                o_hold     = 1'b1;
            end
            SEQ_JZ:   o_next_upc = i_flag_z ? w_upc_inc : SKIP_ADDR;
            SEQ_JN:   o_next_upc = i_flag_n ? w_upc_inc : SKIP_ADDR;
            SEQ_JC:   o_next_upc = i_flag_c ? w_upc_inc : SKIP_ADDR;
            default: begin
                o_next_upc = UPC_W'(FETCH_ADDR);
                o_fetch    = 1'b1;
                o_err      = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/microseq_ctrl.sv
// Microprogram sequencer: owns the micro-PC, the RUN/WAIT/HALT controller,
// the retired-instruction counter and the dispatch/error pulses.
import cpu_pkg::*;

module microseq_ctrl #(
    parameter int               UPC_W     = cpu_pkg::UPC_W,
    parameter int               OPC_W     = cpu_pkg::OPC_W,
    parameter int               SLOT_W    = cpu_pkg::SLOT_W,
    parameter logic [UPC_W-1:0] SKIP_ADDR = cpu_pkg::SKIP_ADDR,
    parameter int               CNT_W     = cpu_pkg::CNT_W
) (
    input  logic            clk,
    input  logic            reset,
    microseq_ctrl_if.slave  bus
);
    state_e           r_state;
    logic [UPC_W-1:0] r_upc;
    logic             r_dispatch;
    logic             r_halted;
    logic             r_ucode_err;
    logic [CNT_W-1:0] r_retired;

    logic [UPC_W-1:0] w_next_upc;
    logic             w_dispatch;
    logic             w_fetch;
    logic             w_err;
    logic             w_hold;

    microseq_ctrl_next_addr #(
        .UPC_W     (UPC_W),
        .OPC_W     (OPC_W),
        .SLOT_W    (SLOT_W),
        .SKIP_ADDR (SKIP_ADDR)
    ) u_next_addr (
        .i_upc       (r_upc),
        .i_seq_op    (bus.seq_op),
        .i_ir_opcode (bus.ir_opcode),
        .i_flag_z    (bus.flag_z),
        .i_flag_n    (bus.flag_n),
        .i_flag_c    (bus.flag_c),
        .o_next_upc  (w_next_upc),
        .o_dispatch  (w_dispatch),
        .o_fetch     (w_fetch),
        .o_err       (w_err),
        .o_hold      (w_hold)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_upc       <= UPC_W'(FETCH_ADDR);
            r_dispatch  <= 1'b0;
            r_halted    <= 1'b0;
            r_ucode_err <= 1'b0;
            r_retired   <= '0;
        end else begin
            r_dispatch  <= 1'b0;
            r_ucode_err <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    // Halting is only allowed on the fetch word, so the word there is not consumed.
                    if (r_upc == UPC_W'(FETCH_ADDR) && bus.halt_req) begin
                        r_state  <= ST_HALT;
                        r_halted <= 1'b1;
                    end else if (w_hold) begin
                        r_state <= ST_WAIT;
                    end else begin
                        r_upc       <= w_next_upc;
                        r_dispatch  <= w_dispatch;
                        r_ucode_err <= w_err;
                        if (w_fetch) begin
                            r_retired <= r_retired + CNT_W'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.mem_ready) begin
                        r_upc   <= r_upc + UPC_W'(1);
                        r_state <= ST_RUN;
                    end
                end
                ST_HALT: begin
                    r_upc <= UPC_W'(FETCH_ADDR);
                    if (!bus.halt_req) begin
                        r_state  <= ST_RUN;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    assign bus.upc       = r_upc;
    assign bus.dispatch  = r_dispatch;
    assign bus.halted    = r_halted;
    assign bus.ucode_err = r_ucode_err;
    assign bus.retired   = r_retired;
endmodule

// File: tb/tb_microseq_ctrl.sv
// Directed bench for microseq_ctrl: a chained vector table for the sequencing
// ops, then hand-written HOLD, halt, mid-state reset and counter-wrap sequences.
module tb_microseq_ctrl;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    microseq_ctrl_if bus ();

    microseq_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  opc;
        logic        z;
        logic        n;
        logic        c;
        logic        hr;
        logic [7:0]  eupc;
        logic        ed;
        logic        eh;
        logic        ee;
        logic [15:0] eret;
    } vec_t;

    vec_t vecs[$];

    localparam logic [2:0] OP_NEXT  = 3'b000;
    localparam logic [2:0] OP_DISP  = 3'b001;
    localparam logic [2:0] OP_FETCH = 3'b010;
    localparam logic [2:0] OP_HOLD  = 3'b011;
    localparam logic [2:0] OP_JZ    = 3'b100;
    localparam logic [2:0] OP_JN    = 3'b101;
    localparam logic [2:0] OP_JC    = 3'b110;
    localparam logic [2:0] OP_RSVD  = 3'b111;

    task automatic add(input logic [2:0] op, input logic [4:0] opc, input logic z,
                       input logic n, input logic c, input logic hr, input logic [7:0] eupc,
                       input logic ed, input logic eh, input logic ee, input logic [15:0] eret);
        vec_t v;
        v = '{op, opc, z, n, c, hr, eupc, ed, eh, ee, eret};
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] eupc, input logic ed,
                           input logic eh, input logic ee, input logic [15:0] eret);
        chk({tag, ".upc"}, 32'(bus.upc), 32'(eupc));
        chk({tag, ".dispatch"}, 32'(bus.dispatch), 32'(ed));
        chk({tag, ".halted"}, 32'(bus.halted), 32'(eh));
        chk({tag, ".ucode_err"}, 32'(bus.ucode_err), 32'(ee));
        chk({tag, ".retired"}, 32'(bus.retired), 32'(eret));
        $display("%s: upc=%02h dispatch=%0d halted=%0d ucode_err=%0d retired=%0d",
                 tag, bus.upc, bus.dispatch, bus.halted, bus.ucode_err, bus.retired);
    endtask

    task automatic drive(input logic [2:0] op, input logic [4:0] opc, input logic mr,
                         input logic hr);
        bus.seq_op    = op;
        bus.ir_opcode = opc;
        bus.mem_ready = mr;
        bus.halt_req  = hr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        bus.flag_z = 1'b0;
        bus.flag_n = 1'b0;
        bus.flag_c = 1'b0;
        drive(OP_NEXT, 5'h00, 1'b0, 1'b0);

        // op opc z n c hr -> upc disp halt err retired
        add(OP_NEXT,  5'h00, 0, 0, 0, 0, 8'h01, 0, 0, 0, 16'd0);
        add(OP_FETCH, 5'h00, 0, 0, 0, 0, 8'h00, 0, 0, 0, 16'd1);
        add(OP_DISP,  5'h09, 0, 0, 0, 0, 8'h48, 1, 0, 0, 16'd1);
        add(OP_NEXT,  5'h09, 0, 0, 0, 0, 8'h49, 0, 0, 0, 16'd1);
        add(OP_FETCH, 5'h09, 0, 0, 0, 0, 8'h00, 0, 0, 0, 16'd2);
        add(OP_DISP,  5'h0B, 0, 0, 0, 0, 8'h58, 1, 0, 0, 16'd2);
        add(OP_JZ,    5'h0B, 1, 0, 0, 0, 8'h59, 0, 0, 0, 16'd2);
        add(OP_JZ,    5'h0B, 0, 1, 1, 0, 8'h80, 0, 0, 0, 16'd2);
        add(OP_JN,    5'h0B, 0, 1, 0, 0, 8'h81, 0, 0, 0, 16'd2);
        add(OP_JN,    5'h0B, 1, 0, 1, 0, 8'h80, 0, 0, 0, 16'd2);
        add(OP_JC,    5'h0B, 0, 0, 1, 0, 8'h81, 0, 0, 0, 16'd2);
        add(OP_JC,    5'h0B, 1, 1, 0, 0, 8'h80, 0, 0, 0, 16'd2);
        add(OP_RSVD,  5'h0B, 0, 0, 0, 0, 8'h00, 0, 0, 1, 16'd3);
        add(OP_DISP,  5'h02, 0, 0, 0, 0, 8'h10, 1, 0, 0, 16'd3);
        for (int i = 1; i <= 7; i++) begin
            add(OP_NEXT, 5'h02, 0, 0, 0, 0, 8'(8'h10 + i), 0, 0, 0, 16'd3);
        end
        add(OP_NEXT,  5'h02, 0, 0, 0, 0, 8'h00, 0, 0, 1, 16'd3);
        add(OP_DISP,  5'h1F, 0, 0, 0, 0, 8'hF8, 1, 0, 0, 16'd3);
        add(OP_JC,    5'h1F, 0, 0, 1, 0, 8'hF9, 0, 0, 0, 16'd3);
        add(OP_FETCH, 5'h1F, 0, 0, 0, 0, 8'h00, 0, 0, 0, 16'd4);

        // Reset held for three edges
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("reset%0d", i), 8'h00, 0, 0, 0, 16'd0);
        end
        reset = 1'b0;

        foreach (vecs[i]) begin
            bus.seq_op    = vecs[i].op;
            bus.ir_opcode = vecs[i].opc;
            bus.flag_z    = vecs[i].z;
            bus.flag_n    = vecs[i].n;
            bus.flag_c    = vecs[i].c;
            bus.halt_req  = vecs[i].hr;
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].eupc, vecs[i].ed, vecs[i].eh,
                    vecs[i].ee, vecs[i].eret);
        end

        // HOLD at 0x31: four ready-low cycles in WAIT, then release
        drive(OP_DISP, 5'h06, 1'b0, 1'b0); tick(); chk_all("hold_disp", 8'h30, 1, 0, 0, 16'd4);
        drive(OP_NEXT, 5'h06, 1'b0, 1'b0); tick(); chk_all("hold_pre", 8'h31, 0, 0, 0, 16'd4);
        drive(OP_HOLD, 5'h06, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_all($sformatf("hold_wait%0d", i), 8'h31, 0, 0, 0, 16'd4);
        end
        bus.mem_ready = 1'b1;
        tick(); chk_all("hold_release", 8'h32, 0, 0, 0, 16'd4);

        // HOLD with mem_ready already high still spends one cycle in WAIT
        drive(OP_HOLD, 5'h06, 1'b1, 1'b0); tick(); chk_all("hold_rdy_wait", 8'h32, 0, 0, 0, 16'd4);
        drive(OP_NEXT, 5'h06, 1'b1, 1'b0); tick(); chk_all("hold_rdy_rel", 8'h33, 0, 0, 0, 16'd4);
        drive(OP_NEXT, 5'h06, 1'b0, 1'b0); tick(); chk_all("hold_rdy_next", 8'h34, 0, 0, 0, 16'd4);

        // Halt requested mid-instruction takes effect only after FETCH
        drive(OP_NEXT, 5'h06, 1'b0, 1'b1);  tick(); chk_all("halt_mid", 8'h35, 0, 0, 0, 16'd4);
        drive(OP_FETCH, 5'h06, 1'b0, 1'b1); tick(); chk_all("halt_fetch", 8'h00, 0, 0, 0, 16'd5);
        drive(OP_NEXT, 5'h06, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all($sformatf("halt_hold%0d", i), 8'h00, 0, 1, 0, 16'd5);
        end
        bus.halt_req = 1'b0;
        tick(); chk_all("halt_leave", 8'h00, 0, 0, 0, 16'd5);
        tick(); chk_all("halt_resume", 8'h01, 0, 0, 0, 16'd5);

        // Reset while in WAIT
        drive(OP_HOLD, 5'h00, 1'b0, 1'b0); tick(); chk_all("rstw_wait", 8'h01, 0, 0, 0, 16'd5);
        reset = 1'b1; tick(); chk_all("rstw_reset", 8'h00, 0, 0, 0, 16'd0);
        reset = 1'b0;
        drive(OP_NEXT, 5'h00, 1'b0, 1'b0); tick(); chk_all("rstw_run", 8'h01, 0, 0, 0, 16'd0);

        // Reset while in HALT
        drive(OP_FETCH, 5'h00, 1'b0, 1'b0); tick(); chk_all("rsth_fetch", 8'h00, 0, 0, 0, 16'd1);
        drive(OP_NEXT, 5'h00, 1'b0, 1'b1);  tick(); chk_all("rsth_halt", 8'h00, 0, 1, 0, 16'd1);
        reset = 1'b1; tick(); chk_all("rsth_reset", 8'h00, 0, 0, 0, 16'd0);
        reset = 1'b0;
        drive(OP_NEXT, 5'h00, 1'b0, 1'b0); tick(); chk_all("rsth_run", 8'h01, 0, 0, 0, 16'd0);

        // Retired counter wrap
        reset = 1'b1; tick(); reset = 1'b0;
        drive(OP_FETCH, 5'h00, 1'b0, 1'b0);
        for (int i = 0; i < 65535; i++) begin
            @(posedge clk);
        end
        #1;
        chk_all("wrap_max", 8'h00, 0, 0, 0, 16'hFFFF);
        tick(); chk_all("wrap_zero", 8'h00, 0, 0, 0, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
